// File: rtl/uart_frame_sender.sv
// uart_frame_sender: frames FFT words as SYNC, LEN, LSB-first payload bytes and a checksum for a byte UART.
module uart_frame_sender #(
  parameter int         WORD_W    = 16,
  parameter int         FRAME_LEN = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              frame_done
);
  typedef enum logic [2:0] {IDLE, SYNC, LEN, LOAD, DATA, CSUM, DONE} state_t;
  typedef enum logic [1:0] {ISSUE, GUARD, WAIT} phase_t;
  localparam logic [1:0] LAST_IDX  = 2'(WORD_W / 8 - 1);
  localparam logic [7:0] LAST_WORD = 8'(FRAME_LEN - 1);
  localparam logic [7:0] LEN_BYTE  = 8'(FRAME_LEN);
  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [7:0]        cnt_q, cnt_d, sum_q, sum_d, tx_data_q, tx_data_d;
  logic [1:0]        idx_q, idx_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        data_byte, cur_byte;
  logic              sending, byte_done;
  assign sending   = state_q inside {SYNC, LEN, DATA, CSUM};
  assign byte_done = sending && phase_q == WAIT && !tx_busy;
  assign data_byte = 8'(word_q >> {idx_q, 3'b000});
  assign cur_byte  = state_q == SYNC ? SYNC_BYTE :
                     state_q == LEN  ? LEN_BYTE  :
                     state_q == DATA ? data_byte : ~sum_q + 8'd1;
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    // GUARD skips one cycle of tx_busy because the transmitter raises it a cycle late
    if (sending && phase_q == ISSUE && !tx_busy) begin
      tx_start_d = 1'b1;
      tx_data_d  = cur_byte;
      phase_d    = GUARD;
      if (state_q == DATA) sum_d = sum_q + cur_byte;
    end else if (sending && phase_q == GUARD) begin
      phase_d = WAIT;
    end
    if (byte_done) phase_d = ISSUE;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SYNC;
        phase_d = ISSUE;
        sum_d   = '0;
      end
      SYNC: if (byte_done) state_d = LEN;
      LEN:  if (byte_done) state_d = LOAD;
      LOAD: if (in_valid) begin
        word_d  = in_data;
        idx_d   = '0;
        phase_d = ISSUE;
        state_d = DATA;
      end
      DATA: if (byte_done) begin
        if (idx_q != LAST_IDX) idx_d = idx_q + 2'd1;
        else if (cnt_q == LAST_WORD) state_d = CSUM;
        else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = LOAD;
        end
      end
      CSUM: if (byte_done) state_d = DONE;
      DONE: begin
        cnt_d   = '0;
        idx_d   = '0;
        sum_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= ISSUE;
      word_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end
  assign in_ready   = state_q == LOAD;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
endmodule

// File: tb/tb_uart_frame_sender.sv
// tb_uart_frame_sender: frame vectors against a one-bit-per-clock 8N2 transmitter model, plus corner sequences.
module tb_uart_frame_sender;
  logic clk = 0, rst;
  always #5 clk = ~clk;
  logic iv, ir, ts, txb, bz, fd, force_busy;
  logic [15:0] id;
  logic [7:0]  td;
  int cnt = 0;
  assign txb = (cnt != 0) | force_busy;
  uart_frame_sender #(.WORD_W(16), .FRAME_LEN(2)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_data(id), .in_ready(ir), .tx_start(ts),
    .tx_data(td), .tx_busy(txb), .busy(bz), .frame_done(fd));
  always @(posedge clk) if (ts) cnt <= 11; else if (cnt != 0) cnt <= cnt - 1;
  logic iv8, ir8, ts8, txb8, bz8, fd8;
  logic [7:0] id8, td8;
  int cnt8 = 0;
  assign txb8 = cnt8 != 0;
  uart_frame_sender #(.WORD_W(8), .FRAME_LEN(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_data(id8), .in_ready(ir8), .tx_start(ts8),
    .tx_data(td8), .tx_busy(txb8), .busy(bz8), .frame_done(fd8));
  always @(posedge clk) if (ts8) cnt8 <= 11; else if (cnt8 != 0) cnt8 <= cnt8 - 1;
  logic [7:0] q[$], q8[$];
  int nstart = 0, nfd = 0, nfd8 = 0, viol = 0;
  logic ts_prev = 0, ts8_prev = 0;
  always @(negedge clk) begin
    if (ts) begin q.push_back(td); nstart++; end
    if (ts8) q8.push_back(td8);
    if (fd) nfd++;
    if (fd8) nfd8++;
    if (ts && (ts_prev || txb)) viol++;
    if (ts8 && (ts8_prev || txb8)) viol++;
    ts_prev  = ts;
    ts8_prev = ts8;
  end
  int n_vec = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct { logic [15:0] w0, w1; int gap; logic [55:0] exp; } vec_t;
  vec_t vt[4];
  task automatic wait_ready(input string name);
    int i = 0;
    while (!ir && i < 2000) begin @(negedge clk); i++; end
    check(name, ir, 1);
  endtask
  task automatic feed(input logic [15:0] w0, input logic [15:0] w1, input int gap);
    int ns;
    logic ok;
    iv = 1; id = w0;
    @(negedge clk);
    wait_ready("ready_w0");
    @(negedge clk);
    if (gap > 0) begin
      iv = 0;
      wait_ready("ready_gap");
      ns = nstart; ok = 1;
      repeat (gap) begin @(negedge clk); if (!ir) ok = 0; end
      check("gap_ready_held", ok, 1);
      check("gap_no_start", nstart - ns, 0);
    end
    iv = 1; id = w1;
    wait_ready("ready_w1");
    @(negedge clk);
    iv = 0;
  endtask
  task automatic finish(input string name, input logic [55:0] exp);
    int i = 0;
    while (!fd && i < 2000) begin @(negedge clk); i++; end
    check({name, " done_seen"}, fd, 1);
    @(negedge clk);
    check({name, " busy_fell"}, bz, 0);
    check({name, " done_pulse"}, fd, 0);
    check({name, " done_count"}, nfd, 1);
    check({name, " nbytes"}, q.size(), 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("%s byte%0d", name, k), q[k], exp[55-8*k -: 8]);
  endtask
  initial begin
    int i, ns, lat;
    rst = 1; iv = 0; id = 0; iv8 = 0; id8 = 0; force_busy = 0;
    vt[0] = '{16'h1234, 16'hABCD, 0,  56'hA5_02_34_12_CD_AB_42};
    vt[1] = '{16'h1234, 16'hABCD, 50, 56'hA5_02_34_12_CD_AB_42};
    vt[2] = '{16'h0000, 16'h0000, 0,  56'hA5_02_00_00_00_00_00};
    vt[3] = '{16'hFFFF, 16'h0001, 0,  56'hA5_02_FF_FF_01_00_01};
    @(negedge clk);
    check("rst in_ready", ir, 0);
    check("rst tx_start", ts, 0);
    check("rst tx_data", td, 0);
    check("rst busy", bz, 0);
    check("rst frame_done", fd, 0);
    @(negedge clk);
    rst = 0;
    for (int v = 0; v < 4; v++) begin
      q.delete(); nfd = 0;
      feed(vt[v].w0, vt[v].w1, vt[v].gap);
      finish($sformatf("vec%0d", v), vt[v].exp);
    end
    q.delete(); nfd = 0;
    force_busy = 1; iv = 1; id = 16'h1234; ns = nstart;
    repeat (100) @(negedge clk);
    check("forced no_start", nstart - ns, 0);
    check("forced busy", bz, 1);
    force_busy = 0; lat = 0;
    while (!ts && lat < 50) begin @(negedge clk); lat++; end
    check("forced sync_latency", lat, 1);
    check("forced sync_byte", td, 8'hA5);
    feed(16'h1234, 16'hABCD, 0);
    finish("forced", vt[0].exp);
    q.delete(); nfd = 0;
    iv = 1; id = 16'h1234; i = 0;
    while (q.size() < 3 && i < 2000) begin @(negedge clk); i++; end
    check("abort third_byte", q.size(), 3);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    check("abort in_ready", ir, 0);
    check("abort tx_start", ts, 0);
    check("abort tx_data", td, 0);
    check("abort busy", bz, 0);
    check("abort frame_done", fd, 0);
    @(negedge clk);
    rst = 0;
    q.delete(); nfd = 0;
    feed(16'h1234, 16'hABCD, 0);
    finish("after_abort", vt[0].exp);
    iv8 = 1; id8 = 8'h80; i = 0;
    while (!ir8 && i < 2000) begin @(negedge clk); i++; end
    check("w8 ready", ir8, 1);
    @(negedge clk);
    iv8 = 0; i = 0;
    while (!fd8 && i < 2000) begin @(negedge clk); i++; end
    check("w8 done_seen", fd8, 1);
    repeat (30) @(negedge clk);
    check("w8 done_count", nfd8, 1);
    check("w8 busy", bz8, 0);
    check("w8 nbytes", q8.size(), 4);
    check("w8 byte0", q8[0], 8'hA5);
    check("w8 byte1", q8[1], 8'h01);
    check("w8 byte2", q8[2], 8'h80);
    check("w8 byte3", q8[3], 8'h80);
    check("tx_start protocol violations", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
